// File: rtl/updown_step_ctrl_pkg.sv
// Shared constants for the up/down counter button front end:
// FSM state encodings and default timing values.
package updown_step_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_RPT  = 2'd2,
      ST_LOCK = 2'd3
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 64;
   localparam int DEF_REPEAT_RATE     = 16;
   localparam bit DEF_REPEAT_EN       = 1'b1;

endpackage

// File: rtl/updown_step_ctrl_btn_debounce.sv
// One push-button conditioner: 2-flop synchronizer, saturating debounce
// counter and a rising-edge pulse of the debounced level.
module btn_debounce
   import updown_step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic Clk,
   input  logic reset,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic             level_dly_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count consecutive disagreeing samples; flip the level on the last one.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer, debounce state and the delayed level used for edge detect.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         cnt_q       <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = level_q & ~level_dly_q;

endmodule

// File: rtl/updown_step_ctrl.sv
// Button front end for the up/down counter: debounces both buttons, issues
// single-cycle Step pulses with auto-repeat, and rejects both-pressed.
module updown_step_ctrl
   import updown_step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter bit REPEAT_EN       = DEF_REPEAT_EN
) (
   input  logic Clk,
   input  logic reset,
   input  logic BtnUp,
   input  logic BtnDown,
   output logic Step,
   output logic UpOrDown,
   output logic Locked
);

   localparam int               RPT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int               RPT_W      = $clog2(RPT_MAX);
   localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);

   logic             up_lvl;
   logic             up_rise;
   logic             dn_lvl;
   logic             dn_rise;
   logic             active_lvl;
   logic             other_lvl;
   state_e           state_q;
   logic [RPT_W-1:0] rpt_cnt_q;
   logic             step_q;
   logic             dir_q;
   logic             locked_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_up (
      .Clk    (Clk),
      .reset  (reset),
      .btn_i  (BtnUp),
      .level_o(up_lvl),
      .rise_o (up_rise)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_dn (
      .Clk    (Clk),
      .reset  (reset),
      .btn_i  (BtnDown),
      .level_o(dn_lvl),
      .rise_o (dn_rise)
   );

   // The accepted direction identifies which button owns the current press.
   assign active_lvl = dir_q ? up_lvl : dn_lvl;
   assign other_lvl  = dir_q ? dn_lvl : up_lvl;

   // Press/repeat/lock FSM with registered Step, direction and lock outputs.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rpt_cnt_q <= '0;
         step_q    <= 1'b0;
         dir_q     <= 1'b1;
         locked_q  <= 1'b0;
      end else begin
         step_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (up_rise && dn_rise) begin
                  locked_q <= 1'b1;
                  state_q  <= ST_LOCK;
               end else if (up_rise || dn_rise) begin
                  step_q    <= 1'b1;
                  dir_q     <= up_rise;
                  rpt_cnt_q <= DELAY_LOAD;
                  state_q   <= ST_HELD;
               end
            end
            ST_HELD, ST_RPT: begin
               // release beats conflict beats repeat
               if (!active_lvl) begin
                  state_q <= ST_IDLE;
               end else if (other_lvl) begin
                  locked_q <= 1'b1;
                  state_q  <= ST_LOCK;
               end else if (REPEAT_EN && (rpt_cnt_q == '0)) begin
                  step_q    <= 1'b1;
                  rpt_cnt_q <= RATE_LOAD;
                  state_q   <= ST_RPT;
               end else if (rpt_cnt_q != '0) begin
                  rpt_cnt_q <= rpt_cnt_q - 1'b1;
               end
            end
            ST_LOCK: begin
               if (!up_lvl && !dn_lvl) begin
                  locked_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Step     = step_q;
   assign UpOrDown = dir_q;
   assign Locked   = locked_q;

endmodule
